vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible lines.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 SHALL have parameter HSYNC_POL, default 0, active level of hsync.
REQ-010 SHALL have parameter VSYNC_POL, default 0, active level of vsync.
REQ-011 SHALL have parameter LOOKAHEAD, default 2, prefetch lead in pixels (1..H_ACTIVE-1).
REQ-012 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-013 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-014 SHALL have port en, input, 1, pixel advance enable.
REQ-015 SHALL have port hsync, output, 1, horizontal sync.
REQ-016 SHALL have port vsync, output, 1, vertical sync.
REQ-017 SHALL have port de, output, 1, display enable (visible pixel).
REQ-018 SHALL have port x, output, HW=$clog2(H_TOTAL), current horizontal position.
REQ-019 SHALL have port y, output, VW=$clog2(V_TOTAL), current vertical position.
REQ-020 SHALL have port line_start, output, 1, one-cycle pulse at x==0.
REQ-021 SHALL have port frame_start, output, 1, one-cycle pulse at x==0 and y==0.
REQ-022 SHALL have port prefetch, output, 1, asserted LOOKAHEAD pixels before each visible pixel.
REQ-023 SHALL have port frame_cnt, output, 8, frame counter (only with VGA_FRAME_COUNTER_EN).

Function
REQ-024 SHALL hold H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL as the vertical sum (800/525 by default).
REQ-025 SHALL advance hcnt by one per clk with en=1; with en=0, counters and all outputs hold.
REQ-026 SHALL wrap hcnt from H_TOTAL-1 to 0 and advance vcnt in the same cycle; vcnt wraps from V_TOTAL-1 to 0.
REQ-027 SHALL register all outputs from the counter state with exactly one cycle of latency, all outputs mutually aligned.
REQ-028 SHALL drive de=1 iff hcnt<H_ACTIVE and vcnt<V_ACTIVE.
REQ-029 SHALL drive hsync=HSYNC_POL iff H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC, else ~HSYNC_POL.
REQ-030 SHALL apply the same rule to vsync on vcnt, independent of hcnt.
REQ-031 SHALL assert prefetch iff the pixel LOOKAHEAD steps ahead, including steps across line and frame wrap, is visible.
REQ-032 SHALL assert line_start and frame_start only in cycles where en was 1 at the preceding edge, so each position pulses once regardless of en stalls.
REQ-033 SHALL, with VGA_FRAME_COUNTER_EN, increment frame_cnt at each vcnt wrap; it wraps 255->0.

Reset
REQ-034 SHALL on rst=1 set hcnt=vcnt=0, x=y=0, de=0, prefetch=0, line_start=frame_start=0, hsync/vsync inactive, frame_cnt=0.
REQ-035 SHALL give rst priority over en; reset mid-frame restarts at (0,0) without a spurious sync pulse.
REQ-036 SHALL, on the first en=1 edge after reset release, output x=0, y=0, de=1, line_start=1, frame_start=1.

Configuration
REQ-037 SHALL compile frame_cnt port and logic only when VGA_FRAME_COUNTER_EN is defined; otherwise the port is absent and the remaining behaviour is identical.

Structure
REQ-038 SHALL place the default 640x480 timing constants and a timing-totals helper in shared package vga_timing_pkg.
REQ-039 SHALL be implemented as a single module; no sub-modules.
REQ-040 SHALL reject at elaboration any parameter set with LOOKAHEAD>=H_ACTIVE or a zero sync width.

Verification
REQ-041 SHALL test defaults, en=1 constantly: hsync low for 96 cycles starting 656 cycles after line_start; line period 800; frame period 420000.
REQ-042 SHALL test vsync low from line 490 to line 491 inclusive; de=0 on lines 480..524.
REQ-043 SHALL test LOOKAHEAD=2: prefetch rises at x=798 of line 524 and falls at x=638 of line 0.
REQ-044 SHALL test en toggled 1/0 every cycle: line period 1600 cycles; line_start pulses exactly once per line.
REQ-045 SHALL test rst asserted at x=700, y=300: next en edge gives x=0, y=0, frame_start=1, hsync high.
REQ-046 SHALL test HSYNC_POL=1 with H_ACTIVE=320, H_FP=8, H_SYNC=48, H_BP=24: hsync high for x 328..375; line period 400.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and totals helper
// shared by the VGA timing generator.
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    function automatic int timing_total(
        input int active,
        input int fp,
        input int sync,
        input int bp
    );
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with registered, aligned outputs.
// Optional frame counter port when VGA_FRAME_COUNTER_EN is defined.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_FP       = VGA_H_FP,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BP       = VGA_H_BP,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_FP       = VGA_V_FP,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BP       = VGA_V_BP,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int LOOKAHEAD  = 2,
    localparam int H_TOTAL   = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL   = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int HW        = $clog2(H_TOTAL),
    localparam int VW        = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [HW-1:0] x,
    output logic [VW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic          prefetch
`ifdef VGA_FRAME_COUNTER_EN
    ,
    output logic [7:0]    frame_cnt
`endif
);

    if (LOOKAHEAD < 1 || LOOKAHEAD >= H_ACTIVE ||
        H_SYNC == 0 || V_SYNC == 0) begin : g_bad_params
        $error("vga_timing_gen: invalid timing parameters");
    end

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          h_last;
    logic          v_last;
    logic          vis;
    logic          h_in_sync;
    logic          v_in_sync;
    logic          pf_next;
    int            h_ahead;
    int            v_ahead;

    always_comb begin
        h_last    = int'(hcnt) == H_TOTAL - 1;
        v_last    = int'(vcnt) == V_TOTAL - 1;
        vis       = int'(hcnt) < H_ACTIVE && int'(vcnt) < V_ACTIVE;
        h_in_sync = int'(hcnt) >= H_ACTIVE + H_FP &&
                    int'(hcnt) <  H_ACTIVE + H_FP + H_SYNC;
        v_in_sync = int'(vcnt) >= V_ACTIVE + V_FP &&
                    int'(vcnt) <  V_ACTIVE + V_FP + V_SYNC;
        // LOOKAHEAD < H_TOTAL, so at most one line wrap ahead
        h_ahead   = int'(hcnt) + LOOKAHEAD;
        v_ahead   = int'(vcnt);
        if (h_ahead >= H_TOTAL) begin
            h_ahead = h_ahead - H_TOTAL;
            v_ahead = v_last ? 0 : v_ahead + 1;
        end
        pf_next   = h_ahead < H_ACTIVE && v_ahead < V_ACTIVE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt        <= '0;
            vcnt        <= '0;
            x           <= '0;
            y           <= '0;
            de          <= 1'b0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            prefetch    <= 1'b0;
        end else if (en) begin
            hcnt <= h_last ? '0 : hcnt + 1'b1;
            if (h_last) begin
                vcnt <= v_last ? '0 : vcnt + 1'b1;
            end
            x           <= hcnt;
            y           <= vcnt;
            de          <= vis;
            hsync       <= h_in_sync ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= v_in_sync ? VSYNC_POL : ~VSYNC_POL;
            line_start  <= hcnt == '0;
            frame_start <= hcnt == '0 && vcnt == '0;
            prefetch    <= pf_next;
        end else begin
            // pulses mark a position once, not every stalled cycle
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

`ifdef VGA_FRAME_COUNTER_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (en && h_last && v_last) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen against a linear-position
// reference model; default and a reduced HSYNC_POL=1 instance.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    always #5 clk = ~clk;

    logic       hs_a, vs_a, de_a, ls_a, fs_a, pf_a;
    logic [9:0] x_a, y_a;
    logic       hs_b, vs_b, de_b, ls_b, fs_b, pf_b;
    logic [8:0] x_b;
    logic [3:0] y_b;
`ifdef VGA_FRAME_COUNTER_EN
    logic [7:0] fc_a, fc_b;
`endif

    vga_timing_gen u_a (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .hsync       (hs_a),
        .vsync       (vs_a),
        .de          (de_a),
        .x           (x_a),
        .y           (y_a),
        .line_start  (ls_a),
        .frame_start (fs_a),
        .prefetch    (pf_a)
`ifdef VGA_FRAME_COUNTER_EN
        ,
        .frame_cnt   (fc_a)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE  (320),
        .H_FP      (8),
        .H_SYNC    (48),
        .H_BP      (24),
        .V_ACTIVE  (6),
        .V_FP      (2),
        .V_SYNC    (2),
        .V_BP      (3),
        .HSYNC_POL (1'b1)
    ) u_b (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .hsync       (hs_b),
        .vsync       (vs_b),
        .de          (de_b),
        .x           (x_b),
        .y           (y_b),
        .line_start  (ls_b),
        .frame_start (fs_b),
        .prefetch    (pf_b)
`ifdef VGA_FRAME_COUNTER_EN
        ,
        .frame_cnt   (fc_b)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int ha[2]  = '{640, 320};
    int hf[2]  = '{16, 8};
    int hsw[2] = '{96, 48};
    int hb[2]  = '{48, 24};
    int va[2]  = '{480, 6};
    int vf[2]  = '{10, 2};
    int vsw[2] = '{2, 2};
    int vb[2]  = '{33, 3};
    bit hp[2]  = '{1'b0, 1'b1};
    bit vp[2]  = '{1'b0, 1'b0};
    int la     = 2;

    int pos[2];
    int ex_x[2], ex_y[2], ex_fc[2];
    bit ex_de[2], ex_hs[2], ex_vs[2];
    bit ex_ls[2], ex_fs[2], ex_pf[2];

    function automatic int htot(input int i);
        return ha[i] + hf[i] + hsw[i] + hb[i];
    endfunction

    function automatic int vtot(input int i);
        return va[i] + vf[i] + vsw[i] + vb[i];
    endfunction

    function automatic bit visible(input int i, input int p);
        return (p % htot(i)) < ha[i] && (p / htot(i)) < va[i];
    endfunction

    task automatic model_edge(input int i);
        int ft, h, v;
        ft = htot(i) * vtot(i);
        if (rst) begin
            pos[i] = 0;
            ex_x[i] = 0; ex_y[i] = 0; ex_de[i] = 0;
            ex_hs[i] = !hp[i]; ex_vs[i] = !vp[i];
            ex_ls[i] = 0; ex_fs[i] = 0; ex_pf[i] = 0;
            ex_fc[i] = 0;
        end else if (en) begin
            h = pos[i] % htot(i);
            v = pos[i] / htot(i);
            ex_x[i]  = h;
            ex_y[i]  = v;
            ex_de[i] = visible(i, pos[i]);
            ex_hs[i] = (h >= ha[i] + hf[i] &&
                        h < ha[i] + hf[i] + hsw[i]) ? hp[i] : !hp[i];
            ex_vs[i] = (v >= va[i] + vf[i] &&
                        v < va[i] + vf[i] + vsw[i]) ? vp[i] : !vp[i];
            ex_ls[i] = h == 0;
            ex_fs[i] = pos[i] == 0;
            ex_pf[i] = visible(i, (pos[i] + la) % ft);
            if (pos[i] == ft - 1) ex_fc[i] = (ex_fc[i] + 1) % 256;
            pos[i] = (pos[i] + 1) % ft;
        end else begin
            ex_ls[i] = 0;
            ex_fs[i] = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        @(negedge clk);
        check("a.x", x_a, ex_x[0]);
        check("a.y", y_a, ex_y[0]);
        check("a.de", de_a, ex_de[0]);
        check("a.hsync", hs_a, ex_hs[0]);
        check("a.vsync", vs_a, ex_vs[0]);
        check("a.line_start", ls_a, ex_ls[0]);
        check("a.frame_start", fs_a, ex_fs[0]);
        check("a.prefetch", pf_a, ex_pf[0]);
        check("b.x", x_b, ex_x[1]);
        check("b.y", y_b, ex_y[1]);
        check("b.de", de_b, ex_de[1]);
        check("b.hsync", hs_b, ex_hs[1]);
        check("b.vsync", vs_b, ex_vs[1]);
        check("b.line_start", ls_b, ex_ls[1]);
        check("b.frame_start", fs_b, ex_fs[1]);
        check("b.prefetch", pf_b, ex_pf[1]);
`ifdef VGA_FRAME_COUNTER_EN
        check("a.frame_cnt", fc_a, ex_fc[0]);
        check("b.frame_cnt", fc_b, ex_fc[1]);
`endif
    endtask

    initial begin
        int n, cnt, first, pulses;

        rst = 1'b1;
        en  = 1'b0;
        repeat (3) step();
        check("rst.x", x_a, 0);
        check("rst.de", de_a, 0);
        check("rst.hsync", hs_a, 1);
        check("rst.b_hsync", hs_b, 0);

        // first enabled edge after reset release
        rst = 1'b0;
        en  = 1'b1;
        step();
        check("first.de", de_a, 1);
        check("first.ls", ls_a, 1);
        check("first.fs", fs_a, 1);

        // default line: hsync lead, width, period
        n = 0;
        while (hs_a && n < 2000) begin step(); n++; end
        check("a.hs_lead", n, 656);
        cnt = 0;
        while (!hs_a && cnt < 2000) begin step(); cnt++; end
        check("a.hs_width", cnt, 96);
        while (!ls_a && n < 4000) begin step(); n++; end
        check("a.line_period", n + cnt, 800);

        // reduced config: hsync high for x 328..375, period 400
        n = 0;
        while (!ls_b && n < 1000) begin step(); n++; end
        check("b.ls_found", n < 1000, 1);
        cnt = 0;
        first = -1;
        for (int k = 0; k < 400; k++) begin
            if (hs_b) begin
                cnt++;
                if (first < 0) first = int'(x_b);
            end
            step();
        end
        check("b.hs_width", cnt, 48);
        check("b.hs_first_x", first, 328);
        check("b.line_period", ls_b, 1);

        // cover reduced-config frame wraps
        repeat (6000) step();

        // en toggling: line takes 1600 cycles, one pulse per line
        n = 0;
        while (!ls_a && n < 2000) begin step(); n++; end
        n = 0;
        pulses = 0;
        do begin
            en = !en;
            step();
            n++;
        end while (!ls_a && n < 4000);
        check("a.toggle_period", n, 1600);
        n = 0;
        for (int k = 0; k < 3200; k++) begin
            en = !en;
            step();
            if (ls_a) pulses++;
        end
        check("a.toggle_pulses", pulses, 2);

        // randomized enable with rare resets
        for (int k = 0; k < 30000; k++) begin
            en  = $urandom_range(0, 3) != 0;
            rst = $urandom_range(0, 4999) == 0;
            step();
        end
        rst = 1'b0;

        // reset mid-line at x=700
        en = 1'b1;
        n = 0;
        while (x_a != 10'd700 && n < 2000) begin step(); n++; end
        check("a.reach_x700", x_a, 700);
        rst = 1'b1;
        step();
        check("mid.rst_hsync", hs_a, 1);
        check("mid.rst_ls", ls_a, 0);
        rst = 1'b0;
        en  = 1'b0;
        step();
        en = 1'b1;
        step();
        check("mid.x", x_a, 0);
        check("mid.y", y_a, 0);
        check("mid.fs", fs_a, 1);
        check("mid.hsync", hs_a, 1);
        repeat (50) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
